// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing logic.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam int         MD_LAT_DEF = 32;
    // Wide enough for the largest legal multiply/divide latency (63).
    localparam int         MD_CNT_W   = 6;

    // A source operand depends on a destination only if it is actually read
    // and the destination is not the hard-wired zero register.
    function automatic logic reg_match(input logic       use_src,
                                       input logic [4:0] src,
                                       input logic [4:0] dst);
        return use_src && (src == dst) && (dst != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use interlock, branch flush,
// multiply/divide occupancy and data-memory wait states.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEF,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       D_Rs,
    input  logic [4:0]       D_Rt,
    input  logic             D_UseRs,
    input  logic             D_UseRt,
    input  logic             E_MemRd,
    input  logic [4:0]       E_Rw,
    input  logic             E_IsMD,
    input  logic             E_BrTaken,
    input  logic             M_MemReq,
    input  logic             mem_ready,
    output logic             PC_En,
    output logic             D_En,
    output logic             E_En,
    output logic             M_En,
    output logic             D_Flush,
    output logic             E_Flush,
    output logic             M_Flush,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    hz_state_t state_reg, state_next;
    hz_state_t saved_reg, saved_next;
    hz_state_t eff_state, post_state;

    logic [MD_CNT_W-1:0] cnt_reg, cnt_next;

    logic [4:0] src     [2];
    logic       use_src [2];
    logic [1:0] src_hit;

    logic wait_now;
    logic md_active;
    logic md_last;
    logic load_use;
    logic launch;

    assign src[0]     = D_Rs;
    assign src[1]     = D_Rt;
    assign use_src[0] = D_UseRs;
    assign use_src[1] = D_UseRt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = reg_match(use_src[gi], src[gi], E_Rw);
        end
    endgenerate

    // While waiting on memory the controller behaves as the interrupted state,
    // so the cycle that sees mem_ready is handled exactly like that state.
    always_comb begin
        eff_state = (state_reg == MEM_WAIT) ? saved_reg : state_reg;
        wait_now  = M_MemReq && !mem_ready;
        md_active = (eff_state == MD_BUSY);
        md_last   = md_active && (cnt_reg == '0);
        load_use  = E_MemRd && (|src_hit);
        launch    = (eff_state == RUN) && !wait_now && E_IsMD;
    end

    always_comb begin
        post_state = RUN;
        case (eff_state)
            RUN:     post_state = launch  ? MD_BUSY : RUN;
            MD_BUSY: post_state = md_last ? RUN     : MD_BUSY;
            default: post_state = RUN;
        endcase

        state_next = wait_now ? MEM_WAIT   : post_state;
        saved_next = wait_now ? post_state : saved_reg;

        // The MDU keeps counting through memory waits.
        cnt_next = cnt_reg;
        if (launch) begin
            cnt_next = MD_CNT_W'(MD_LAT - 1);
        end else if (md_active && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            saved_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            saved_reg <= saved_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        PC_En    = 1'b1;
        D_En     = 1'b1;
        E_En     = 1'b1;
        M_En     = 1'b1;
        D_Flush  = 1'b0;
        E_Flush  = 1'b0;
        M_Flush  = 1'b0;
        md_start = 1'b0;
        md_busy  = 1'b0;

        if (rst) begin
            PC_En   = 1'b0;
            D_En    = 1'b0;
            E_En    = 1'b0;
            M_En    = 1'b0;
            D_Flush = 1'b1;
            E_Flush = 1'b1;
            M_Flush = 1'b1;
        end else if (wait_now) begin
            PC_En   = 1'b0;
            D_En    = 1'b0;
            E_En    = 1'b0;
            M_En    = 1'b0;
            md_busy = md_active;
        end else if (md_active) begin
            // Front end frozen; bubbles drain MEM/WB behind the MD instruction.
            PC_En   = 1'b0;
            D_En    = 1'b0;
            E_En    = 1'b0;
            M_Flush = 1'b1;
            md_busy = 1'b1;
        end else begin
            md_start = launch;
            if (E_BrTaken) begin
                D_Flush = 1'b1;
                E_Flush = 1'b1;
            end else if (load_use) begin
                PC_En   = 1'b0;
                D_En    = 1'b0;
                E_Flush = 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .srst  (rst),
        .inc   (!PC_En),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle
// sequences and randomized traffic against a remaining-cycles model.
module tb_hazard_ctrl;

    localparam int MD_LAT = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] D_Rs, D_Rt, E_Rw;
    logic       D_UseRs, D_UseRt, E_MemRd, E_IsMD, E_BrTaken, M_MemReq, mem_ready;

    // {PC_En, D_En, E_En, M_En, D_Flush, E_Flush, M_Flush, md_start, md_busy}
    logic [8:0]  o16, o4;
    logic [15:0] stall16;
    logic [3:0]  stall4;

    hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .D_Rs(D_Rs), .D_Rt(D_Rt), .D_UseRs(D_UseRs), .D_UseRt(D_UseRt),
        .E_MemRd(E_MemRd), .E_Rw(E_Rw), .E_IsMD(E_IsMD), .E_BrTaken(E_BrTaken),
        .M_MemReq(M_MemReq), .mem_ready(mem_ready),
        .PC_En(o16[8]), .D_En(o16[7]), .E_En(o16[6]), .M_En(o16[5]),
        .D_Flush(o16[4]), .E_Flush(o16[3]), .M_Flush(o16[2]),
        .md_start(o16[1]), .md_busy(o16[0]), .stall_cnt(stall16)
    );

    hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .D_Rs(D_Rs), .D_Rt(D_Rt), .D_UseRs(D_UseRs), .D_UseRt(D_UseRt),
        .E_MemRd(E_MemRd), .E_Rw(E_Rw), .E_IsMD(E_IsMD), .E_BrTaken(E_BrTaken),
        .M_MemReq(M_MemReq), .mem_ready(mem_ready),
        .PC_En(o4[8]), .D_En(o4[7]), .E_En(o4[6]), .M_En(o4[5]),
        .D_Flush(o4[4]), .E_Flush(o4[3]), .M_Flush(o4[2]),
        .md_start(o4[1]), .md_busy(o4[0]), .stall_cnt(stall4)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: MD cycles still to freeze, plus the two stall counts.
    int m_rem  = 0;
    int m_c16  = 0;
    int m_c4   = 0;

    typedef struct {
        logic [4:0] rs, rt, rw;
        logic       urs, urt, memrd, br, req, rdy;
        logic [7:0] exp;   // {PC,D,E,M en, D,E,M flush, md_start}
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                                input logic urt, input logic memrd, input logic [4:0] rw,
                                input logic br, input logic req, input logic rdy,
                                input logic [7:0] exp);
        vec_t v;
        v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt; v.memrd = memrd;
        v.rw = rw; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b0; D_Rs = '0; D_Rt = '0; E_Rw = '0;
        D_UseRs = 1'b0; D_UseRt = 1'b0; E_MemRd = 1'b0; E_IsMD = 1'b0;
        E_BrTaken = 1'b0; M_MemReq = 1'b0; mem_ready = 1'b1;
    endtask

    // Check one cycle against the model, then advance the clock and the model.
    task automatic step(output logic [8:0] obs);
        logic [8:0] e;
        logic busy, wt, lu;
        #1;
        busy = (m_rem > 0);
        wt   = M_MemReq && !mem_ready;
        lu   = E_MemRd && (E_Rw != 5'd0) &&
               ((D_UseRs && D_Rs == E_Rw) || (D_UseRt && D_Rt == E_Rw));
        if (rst)       e = 9'b0000_111_0_0;
        else if (wt)   e = {8'b0000_000_0, busy};
        else if (busy) e = 9'b0001_001_0_1;
        else begin
            e = 9'b1111_000_0_0;
            if (E_BrTaken) begin
                e[4] = 1'b1; e[3] = 1'b1;
            end else if (lu) begin
                e[8] = 1'b0; e[7] = 1'b0; e[3] = 1'b1;
            end
            e[1] = E_IsMD;
        end
        chk("outputs_w16", 32'(o16), 32'(e));
        chk("outputs_w4", 32'(o4), 32'(e));
        chk("stall_cnt_w16", 32'(stall16), 32'(m_c16));
        chk("stall_cnt_w4", 32'(stall4), 32'(m_c4));
        obs = o16;
        if (rst) begin
            m_rem = 0; m_c16 = 0; m_c4 = 0;
        end else begin
            if (!e[8]) begin
                if (m_c16 < 65535) m_c16++;
                if (m_c4 < 15) m_c4++;
            end
            if (busy) m_rem--;
            else if (!wt && E_IsMD) m_rem = MD_LAT;
        end
        @(posedge clk);
        #1;
    endtask

    logic [8:0] obs;
    int busy_n, pc0_n, men0_n, first_run, s0;

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(obs);                     // reset outputs and cleared counters
        rst = 1'b0;

        tbl[0]  = mk(5'd8, 1, 5'd0, 0, 1, 5'd8, 0, 0, 1, 8'b0011_0100); // load-use Rs
        tbl[1]  = mk(5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 8'b1111_0000); // released
        tbl[2]  = mk(5'd0, 1, 5'd0, 0, 1, 5'd0, 0, 0, 1, 8'b1111_0000); // $0 dest
        tbl[3]  = mk(5'd8, 0, 5'd0, 0, 1, 5'd8, 0, 0, 1, 8'b1111_0000); // Rs not used
        tbl[4]  = mk(5'd0, 0, 5'd8, 1, 1, 5'd8, 0, 0, 1, 8'b0011_0100); // load-use Rt
        tbl[5]  = mk(5'd8, 1, 5'd0, 0, 1, 5'd8, 1, 0, 1, 8'b1111_1100); // branch wins
        tbl[6]  = mk(5'd8, 1, 5'd0, 0, 0, 5'd8, 0, 0, 1, 8'b1111_0000); // not a load
        tbl[7]  = mk(5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 8'b0000_0000); // wait, branch held
        tbl[8]  = mk(5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 8'b0000_0000);
        tbl[9]  = mk(5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 1, 1, 8'b1111_1100); // flushed on exit
        tbl[10] = mk(5'd5, 1, 5'd7, 1, 1, 5'd5, 0, 0, 1, 8'b0011_0100);
        tbl[11] = mk(5'd5, 1, 5'd7, 1, 1, 5'd5, 0, 1, 0, 8'b0000_0000); // wait beats load-use
        tbl[12] = mk(5'd5, 1, 5'd7, 1, 1, 5'd5, 0, 0, 1, 8'b0011_0100);

        for (int i = 0; i < 13; i++) begin
            idle();
            D_Rs = tbl[i].rs; D_UseRs = tbl[i].urs; D_Rt = tbl[i].rt; D_UseRt = tbl[i].urt;
            E_MemRd = tbl[i].memrd; E_Rw = tbl[i].rw; E_BrTaken = tbl[i].br;
            M_MemReq = tbl[i].req; mem_ready = tbl[i].rdy;
            step(obs);
            chk($sformatf("table_%0d", i), 32'(obs[8:1]), 32'(tbl[i].exp));
        end
        idle();
        step(obs);
        chk("table_stall_total", 32'(stall16), 32'd7);

        // MDU launch and full occupancy
        s0 = m_c16;
        E_IsMD = 1'b1;
        step(obs);
        chk("md_start_pulse", 32'(obs[1]), 32'd1);
        E_IsMD = 1'b0;
        busy_n = 0; pc0_n = 0; first_run = -1;
        for (int k = 1; k <= 34; k++) begin
            step(obs);
            if (obs[0]) busy_n++;
            if (!obs[8]) pc0_n++;
            if (obs[1]) chk("md_start_repeat", 32'(obs[1]), 32'd0);
            if (first_run < 0 && !obs[0]) first_run = k;
        end
        chk("md_busy_cycles", 32'(busy_n), 32'(MD_LAT));
        chk("md_pc_stall_cycles", 32'(pc0_n), 32'(MD_LAT));
        chk("md_first_run_cycle", 32'(first_run), 32'(MD_LAT + 1));
        chk("md_stall_delta", 32'(stall16), 32'(s0 + MD_LAT));

        // Memory wait inside the MDU freeze
        s0 = m_c16;
        E_IsMD = 1'b1;
        step(obs);
        E_IsMD = 1'b0;
        busy_n = 0; men0_n = 0; first_run = -1;
        for (int k = 1; k <= 34; k++) begin
            M_MemReq  = (k >= 10 && k <= 15);
            mem_ready = !(k >= 10 && k <= 14);
            step(obs);
            if (obs[0]) busy_n++;
            if (!obs[5]) men0_n++;
            if (first_run < 0 && !obs[0]) first_run = k;
        end
        idle();
        chk("mdwait_m_en_low", 32'(men0_n), 32'd5);
        chk("mdwait_busy_cycles", 32'(busy_n), 32'(MD_LAT));
        chk("mdwait_first_run_cycle", 32'(first_run), 32'(MD_LAT + 1));
        chk("mdwait_stall_delta", 32'(stall16), 32'(s0 + MD_LAT));

        // Reset in the middle of the MDU freeze
        E_IsMD = 1'b1;
        step(obs);
        E_IsMD = 1'b0;
        for (int k = 1; k <= 6; k++) step(obs);
        rst = 1'b1;
        step(obs);
        chk("rst_flushes", 32'(obs[4:2]), 32'b111);
        rst = 1'b0;
        step(obs);
        chk("rst_md_busy", 32'(obs[0]), 32'd0);
        chk("rst_pc_en", 32'(obs[8]), 32'd1);
        chk("rst_stall_cnt", 32'(stall16), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step(obs);
            chk("rst_no_md_start", 32'(obs[1]), 32'd0);
        end

        // Saturation of the narrow counter
        rst = 1'b1;
        step(obs);
        rst = 1'b0;
        M_MemReq = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k < 20; k++) step(obs);
        idle();
        step(obs);
        chk("sat_w4_hold", 32'(stall4), 32'd15);
        chk("sat_w16_count", 32'(stall16), 32'd20);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 299) == 0);
            D_Rs      = 5'($urandom_range(0, 3));
            D_Rt      = 5'($urandom_range(0, 3));
            E_Rw      = 5'($urandom_range(0, 3));
            D_UseRs   = 1'($urandom_range(0, 1));
            D_UseRt   = 1'($urandom_range(0, 1));
            E_MemRd   = ($urandom_range(0, 2) == 0);
            E_IsMD    = ($urandom_range(0, 39) == 0);
            E_BrTaken = ($urandom_range(0, 7) == 0);
            M_MemReq  = ($urandom_range(0, 2) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            step(obs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
